// File: rtl/wb_port_arb.sv
// wb_port_arb: shares the regfile write port between pipeline writeback and a load-return FIFO.
// Define WB_ARB_PERF_EN to add perf_stall_cnt, a saturating count of pipe stall cycles.
module wb_port_arb #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_valid,
  input  logic [4:0]                pipe_rd,
  input  logic [XLEN-1:0]           pipe_data,
  output logic                      pipe_stall,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [4:0]                lsu_rd,
  input  logic [XLEN-1:0]           lsu_data,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic [$clog2(LQ_DEPTH):0] lq_count
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]               perf_stall_cnt
`endif
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_PIPE, S_LSU} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic [4:0]      lq_rd_mem   [LQ_DEPTH];
  logic [XLEN-1:0] lq_data_mem [LQ_DEPTH];

  logic            push;
  logic            q_nonempty;
  logic            grant_pipe;
  logic            grant_lq;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  // Readiness uses the pre-dequeue count, so a full queue refuses a push even while draining.
  assign lsu_ready  = (count_q != CW'(LQ_DEPTH));
  assign q_nonempty = (count_q != '0);
  assign push       = lsu_valid && lsu_ready;
  assign head_rd    = lq_rd_mem[rd_ptr_q];
  assign head_data  = lq_data_mem[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    grant_pipe = 1'b0;
    grant_lq   = 1'b0;
    pipe_stall = 1'b0;

    case (state_q)
      S_PIPE: begin
        if (pipe_valid) begin
          grant_pipe = 1'b1;
        end else if (q_nonempty) begin
          grant_lq = 1'b1;
        end
      end
      S_LSU: begin
        grant_lq   = q_nonempty;
        pipe_stall = pipe_valid;
      end
      default: ;
    endcase

    count_d  = count_q + CW'(push) - CW'(grant_lq);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = grant_lq ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case (state_q)
      S_PIPE: begin
        if (grant_pipe && q_nonempty) begin
          wait_d = wait_q + WW'(1);
        end else begin
          wait_d = '0;
        end
        // Starvation limit reached, or queue full at end of cycle: force one drain cycle.
        if ((grant_pipe && q_nonempty && wait_q == WW'(MAX_WAIT - 1)) ||
            count_d == CW'(LQ_DEPTH)) begin
          state_d = S_LSU;
          wait_d  = '0;
        end
      end
      S_LSU: begin
        wait_d  = '0;
        state_d = S_PIPE;
      end
      default: state_d = S_PIPE;
    endcase

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_pipe && pipe_rd != 5'd0) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_data;
    end else if (grant_lq && head_rd != 5'd0) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_PIPE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Queue storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd_mem[wr_ptr_q]   <= lsu_rd;
      lq_data_mem[wr_ptr_q] <= lsu_data;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign lq_count = count_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (pipe_stall && perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule
